// File: rtl/fpu_pkg.sv
// Shared types and constants for the 16-bit signed integer to IEEE-754 single converter.
package fpu_pkg;

  localparam int INT_W      = 16;
  localparam int EXP_W      = 8;
  localparam int MANT_W     = 23;
  localparam int FLOAT_BIAS = 127;

  // Exponent of a magnitude whose MSB sits at bit INT_W-1, before any normalising shift.
  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(INT_W - 1 + FLOAT_BIAS);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } float_t;

  // |v| as unsigned; the most negative input wraps to 0x8000, which is the correct magnitude.
  function automatic logic [INT_W-1:0] int_magnitude(input logic signed [INT_W-1:0] v);
    logic [INT_W-1:0] u;
    u = v;
    return v[INT_W-1] ? (~u + 1'b1) : u;
  endfunction

endpackage

// File: rtl/float_norm_stage.sv
// Magnitude/exponent normalisation registers; shifts mag left until its MSB is set.
// I2F_FAST_NORM_EN: shift by 4 whenever the top nibble of mag is zero.
module float_norm_stage
  import fpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    step,
  input  logic signed [INT_W-1:0] in_int,
  output logic                    sign,
  output logic [INT_W-1:0]        mag,
  output logic [EXP_W-1:0]        exp,
  output logic                    norm_done
);

  logic [2:0] shamt;

  assign norm_done = mag[INT_W-1];

  always_comb begin
    shamt = 3'd1;
`ifdef I2F_FAST_NORM_EN
    if (mag[INT_W-1 -: 4] == 4'd0) shamt = 3'd4;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sign <= 1'b0;
      mag  <= '0;
      exp  <= '0;
    end else if (load) begin
      sign <= in_int[INT_W-1];
      mag  <= int_magnitude(in_int);
      exp  <= EXP_INIT;
    end else if (step && !norm_done) begin
      mag  <= mag << shamt;
      exp  <= exp - EXP_W'(shamt);
    end
  end

endmodule

// File: rtl/signed_int_to_float.sv
// Multi-cycle exact conversion of a 16-bit signed integer to IEEE-754 single with valid/ready handshake.
// Optional macro I2F_FAST_NORM_EN speeds up normalisation (results unchanged).
module signed_int_to_float
  import fpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [INT_W-1:0] in_int,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_float
);

  state_t           state_q, state_d;
  float_t           result_q;
  logic             accept;
  logic             sign;
  logic [INT_W-1:0] mag;
  logic [EXP_W-1:0] exp;
  logic             norm_done;

  assign in_ready  = (state_q == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_float = result_q;

  float_norm_stage u_norm (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .step      (state_q == NORM),
    .in_int    (in_int),
    .sign      (sign),
    .mag       (mag),
    .exp       (exp),
    .norm_done (norm_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (in_int == '0) ? DONE : NORM;
      NORM: if (norm_done) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Hidden leading one is dropped; low mantissa bits are always zero for a 16-bit source.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      result_q <= '0;
    end else if (state_q == NORM && norm_done) begin
      result_q <= '{sign: sign, exp: exp,
                    mant: {mag[INT_W-2:0], {(MANT_W-INT_W+1){1'b0}}}};
    end
  end

endmodule

// File: tb/tb_signed_int_to_float.sv
// Directed, table-driven bench for signed_int_to_float plus backpressure, reset-abort and input-change sequences.
module tb_signed_int_to_float;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_int;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_float;

  int checks = 0;
  int errors = 0;

  signed_int_to_float dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_int    (in_int),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_float (out_float)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic [31:0] result;
    int          lat_slow;
    int          lat_fast;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic int pick_lat(input vec_t v);
`ifdef I2F_FAST_NORM_EN
    return v.lat_fast;
`else
    return v.lat_slow;
`endif
  endfunction

  // Edge 1 is the accept edge; lat is the edge after which out_valid must first be seen.
  task automatic convert(input logic [15:0] v, input logic [31:0] res, input int lat,
                         input bit scramble, input string name);
    int seen;
    seen = 0;
    chk({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_int   = v;
    in_valid = 1'b1;
    for (int k = 1; k <= 40 && seen == 0; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (scramble) in_int = 16'(k * 16'h1357 + 16'h7F00);
      if (out_valid) seen = k;
    end
    chk({name, " latency"}, 32'(seen), 32'(lat));
    chk({name, " result"}, out_float, res);
    @(posedge clk); #1;
    chk({name, " out_valid after handoff"}, 32'(out_valid), 32'd0);
    chk({name, " in_ready after handoff"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{16'h0005, 32'h40A00000, 15, 6};
    vecs[1] = '{16'hFFFF, 32'hBF800000, 17, 8};
    vecs[2] = '{16'h8000, 32'hC7000000,  2, 2};
    vecs[3] = '{16'h7FFF, 32'h46FFFE00,  3, 3};
    vecs[4] = '{16'h0000, 32'h00000000,  1, 1};
    vecs[5] = '{16'h0001, 32'h3F800000, 17, 8};
    vecs[6] = '{16'h0002, 32'h40000000, 16, 7};
    vecs[7] = '{16'hFFFE, 32'hC0000000, 16, 7};
    vecs[8] = '{16'h1000, 32'h45800000,  5, 5};
    vecs[9] = '{16'h0100, 32'h43800000,  9, 6};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_int    = 16'h1234;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_float", out_float, 32'h0);
    reset = 1'b0;
    #1;
    chk("in_ready after reset", 32'(in_ready), 32'd1);

    foreach (vecs[i])
      convert(vecs[i].value, vecs[i].result, pick_lat(vecs[i]), 1'b0, $sformatf("vec%0d", i));

    // Backpressure: three DONE cycles without out_ready, handoff on the fourth.
    begin
      int seen;
      logic [31:0] held;
      seen = 0;
      out_ready = 1'b0;
      in_int    = 16'h8000;
      in_valid  = 1'b1;
      for (int k = 1; k <= 40 && seen == 0; k++) begin
        @(posedge clk); #1;
        in_int = 16'h0005;
        if (out_valid) seen = k;
      end
      chk("bp latency", 32'(seen), 32'd2);
      held = out_float;
      chk("bp result", held, 32'hC7000000);
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("bp out_valid c%0d", c), 32'(out_valid), 32'd1);
        chk($sformatf("bp out_float c%0d", c), out_float, 32'hC7000000);
        chk($sformatf("bp in_ready c%0d", c), 32'(in_ready), 32'd0);
        if (c < 2) begin
          @(posedge clk); #1;
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp out_valid after handoff", 32'(out_valid), 32'd0);
      chk("bp in_ready after handoff", 32'(in_ready), 32'd1);
    end

    // Reset during the third NORM cycle aborts the conversion.
    begin
      int stray;
      stray    = 0;
      in_int   = 16'h0001;
      in_valid = 1'b1;
      repeat (3) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      chk("abort out_valid before reset", 32'(out_valid), 32'd0);
      reset = 1'b1;
      #1;
      chk("abort in_ready during reset", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("abort in_ready after reset", 32'(in_ready), 32'd1);
      chk("abort out_float after reset", out_float, 32'h0);
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (out_valid) stray++;
      end
      chk("abort no stray output", 32'(stray), 32'd0);
      convert(16'h0002, 32'h40000000, pick_lat(vecs[6]), 1'b0, "after abort");
    end

    // Input changes after accept must not affect the result.
    convert(16'h0005, 32'h40A00000, pick_lat(vecs[0]), 1'b1, "scrambled 5");
    convert(16'hFFFF, 32'hBF800000, pick_lat(vecs[1]), 1'b1, "scrambled -1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
